// File: rtl/param_updown_counter_pkg.sv
// Shared types and mode constants for the parametrised up/down counter and its step datapath.

package param_updown_counter_pkg;

    localparam int unsigned CntModeWrap = 0;
    localparam int unsigned CntModeSat  = 1;

    typedef enum logic {
        DirDown = 1'b0,
        DirUp   = 1'b1
    } dir_e;

    typedef struct packed {
        logic ovf;
        logic unf;
    } cnt_flags_t;

endpackage

// File: rtl/mod_step_addsub.sv
// Combinational modular add/subtract of one effective step, with wrap or saturate at the
// 0 / MAX_VAL boundaries and a flag reporting that a boundary was crossed.

module mod_step_addsub
    import param_updown_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX_VAL  = (1 << WIDTH) - 1,
    parameter int unsigned MODE_SAT = CntModeWrap
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic [WIDTH-1:0] s_i,
    input  dir_e             dir_i,
    output logic [WIDTH-1:0] next_count_o,
    output logic             crossed_o
);

    localparam logic [WIDTH:0]   MaxExt  = (WIDTH + 1)'(MAX_VAL);
    localparam logic [WIDTH:0]   Modulus = MaxExt + 1'b1;
    localparam logic [WIDTH-1:0] MaxVal  = WIDTH'(MAX_VAL);
    localparam bit               Sat     = (MODE_SAT == CntModeSat);

    logic [WIDTH:0] count_ext;
    logic [WIDTH:0] s_ext;
    logic [WIDTH:0] sum;

    assign count_ext = {1'b0, count_i};
    assign s_ext     = {1'b0, s_i};
    // One extra bit so the carry past MAX_VAL is never lost, even when MAX_VAL = 2^WIDTH-1.
    assign sum       = count_ext + s_ext;

    always_comb begin
        next_count_o = count_i;
        crossed_o    = 1'b0;
        if (dir_i == DirUp) begin
            if (sum > MaxExt) begin
                crossed_o    = 1'b1;
                next_count_o = Sat ? MaxVal : WIDTH'(sum - Modulus);
            end else begin
                next_count_o = sum[WIDTH-1:0];
            end
        end else begin
            if (s_ext > count_ext) begin
                crossed_o    = 1'b1;
                next_count_o = Sat ? '0 : WIDTH'(count_ext + Modulus - s_ext);
            end else begin
                next_count_o = count_i - s_i;
            end
        end
    end

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter: load > enable > hold priority, runtime step, wrap or
// saturate at MAX_VAL, registered overflow/underflow pulses and a direction-aware terminal count.

module param_updown_counter
    import param_updown_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX_VAL  = (1 << WIDTH) - 1,
    parameter int unsigned MODE_SAT = CntModeWrap
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic             up_down,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] count_out,
    output logic             tc,
    output logic             ovf,
    output logic             unf
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    cnt_flags_t       flags_q;
    cnt_flags_t       flags_d;

    dir_e             dir;
    logic [WIDTH-1:0] step_eff;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] step_next;
    logic             crossed;

    assign dir      = up_down ? DirUp : DirDown;
    assign step_eff = (step > MaxVal) ? MaxVal : step;
    assign load_val = (data_in > MaxVal) ? MaxVal : data_in;

    mod_step_addsub #(
        .WIDTH    (WIDTH),
        .MAX_VAL  (MAX_VAL),
        .MODE_SAT (MODE_SAT)
    ) u_step_addsub (
        .count_i      (count_q),
        .s_i          (step_eff),
        .dir_i        (dir),
        .next_count_o (step_next),
        .crossed_o    (crossed)
    );

    always_comb begin
        count_d = count_q;
        flags_d = '0;
        if (load) begin
            count_d = load_val;
        end else if (en && (step_eff != '0)) begin
            count_d     = step_next;
            flags_d.ovf = crossed && (dir == DirUp);
            flags_d.unf = crossed && (dir == DirDown);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            flags_q <= '0;
        end else begin
            count_q <= count_d;
            flags_q <= flags_d;
        end
    end

    assign count_out = count_q;
    assign ovf       = flags_q.ovf;
    assign unf       = flags_q.unf;
    // Terminal count follows the requested direction even while counting is disabled.
    assign tc        = (dir == DirUp) ? (count_q == MaxVal) : (count_q == '0);

    a_flags_exclusive: assert property (@(posedge clk) disable iff (!reset)
        !(flags_q.ovf && flags_q.unf));

    a_count_in_range: assert property (@(posedge clk) disable iff (!reset)
        count_q <= MaxVal);

endmodule
